mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage data access engine of the 5-stage pipeline. It sits directly upstream of the M/WB pipeline register and produces Do_M.
- Converts the M-stage load/store request into a word-aligned request on the data bus, using a req/ack handshake and byte enables.
- Stalls the pipeline until the access completes.
- Formats load data (byte/half/word, sign/zero extension) and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: maximum BUSY cycles without bus_ack before the access is aborted as a bus error.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- Resetn  in  1  synchronous, active-low reset
- MemRd_M  in  1  load in M stage
- MemWr_M  in  1  store in M stage
- MemSize_M  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- MemSext_M  in  1  1 = sign-extend load, 0 = zero-extend
- ALUout_M  in  32  effective byte address
- Wdata_M  in  32  store data, right-justified
- Do_M  out  32  formatted load data; registered; consumed by M/WB
- Stall_M  out  1  freeze all upstream stages and the M/WB register
- AddrErr_M  out  1  misaligned access (combinational)
- BusErr_M  out  1  last access timed out (registered)
- bus_req  out  1  bus request (registered)
- bus_we  out  1  1 = write
- bus_addr  out  32  {ALUout_M[31:2], 2'b00}, held for the whole request
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  completion; sampled only while bus_req = 1

Behaviour:
- Access = MemRd_M | MemWr_M. If both are set, the write wins (bus_we = 1) and no load data is captured.
- Misaligned means either half with ALUout_M[0] = 1, or word with ALUout_M[1:0] != 0.
  - AddrErr_M = access & misaligned.
  - A misaligned access issues no bus request and raises no stall.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if access & !misaligned, go to BUSY. On that edge:
    - latch bus_addr, bus_we, bus_be, bus_wdata, size, sext, addr[1:0];
    - set bus_req = 1;
    - clear the timeout counter and BusErr_M.
  - BUSY: bus_req held at 1 with stable bus_addr/bus_we/bus_be/bus_wdata; counter increments each cycle.
    - On bus_ack = 1: bus_req goes to 0 and the FSM goes to DONE. For a load, Do_M is loaded with the formatted bus_rdata.
    - Else, when counter == TIMEOUT-1: bus_req goes to 0, BusErr_M goes to 1, Do_M goes to 0, and the FSM goes to DONE.
  - DONE: the pipeline advances this cycle. Next state is IDLE unconditionally, so a back-to-back access is seen one cycle later.
- Stall_M (combinational) = (IDLE & access & !misaligned) | BUSY. It is 0 in DONE.
- Minimum load/store latency: 2 stall cycles (ack in the first BUSY cycle).
- Store lanes:
  - byte: wdata = {4{Wdata_M[7:0]}}, be = 4'b0001 << addr[1:0]
  - half: wdata = {2{Wdata_M[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011
  - word: wdata = Wdata_M, be = 4'b1111
- Load format:
  - Select the byte rdata[8*a +: 8] or the half rdata[16*a[1] +: 16], where a = latched addr[1:0].
  - Extend to 32 bits per the latched sext. Word loads pass through.
- Do_M is held until the next load completes or a timeout occurs. Stores and misaligned accesses leave Do_M unchanged.
- bus_we, bus_be and bus_wdata are don't-care while bus_req = 0. They are driven from the latched values.
- Reset (Resetn = 0 at a rising edge), in any state including mid-BUSY:
  - state = IDLE, bus_req = 0, Do_M = 0, BusErr_M = 0, counter = 0;
  - the abandoned bus transaction is not completed;
  - bus_ack arriving after reset is ignored because bus_req = 0.

Decomposition:
- Shared package holds:
  - MemSize encodings (SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10);
  - FSM state encoding (IDLE, BUSY, DONE);
  - default TIMEOUT.
- One sub-module: load_formatter, a combinational block taking rdata, addr[1:0], size and sext and returning the 32-bit extended result. It is reused by the instruction-side path.

Test Plan:
- Load word:
  - Stimulus: lw to 0x100; bus_ack in the 1st BUSY cycle with rdata 0xDEADBEEF.
  - Response: Stall_M high for exactly 2 cycles; bus_be = 4'b1111, bus_addr = 0x100; Do_M = 0xDEADBEEF in DONE.
- Signed byte load:
  - Stimulus: lb to 0x103 with rdata 0x80112233, ack delayed 3 cycles.
  - Response: Stall_M high for 4 cycles; Do_M = 0xFFFFFF80. Same access as lbu gives Do_M = 0x00000080.
- Half store:
  - Stimulus: sh with Wdata 0x0000ABCD to 0x206.
  - Response: bus_addr = 0x204, bus_be = 4'b1100, bus_wdata = 0xABCDABCD, bus_we = 1; Do_M unchanged.
- Misaligned:
  - Stimulus: lw to 0x102.
  - Response: AddrErr_M = 1, Stall_M = 0, bus_req never asserted.
- Timeout:
  - Stimulus: lw with no ack, TIMEOUT = 16.
  - Response: bus_req drops after 16 BUSY cycles; BusErr_M = 1, Do_M = 0; Stall_M released in DONE.
- Reset mid-access:
  - Stimulus: Resetn = 0 during the 2nd BUSY cycle, then bus_ack pulses after reset.
  - Response: next edge gives bus_req = 0, Stall_M = 0, Do_M = 0; the late ack causes no state change.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the M-stage data access engine: size codes, FSM
// encoding, timeout defaults and lane helpers.
package mem_access_unit_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int TIMEOUT_DEF = 16;
   localparam int CNT_W_DEF   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Reserved size 2'b11 behaves as a word everywhere.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = addr_lo[0];
         default: mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << addr_lo;
         SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SZ_BYTE: d = {4{wdata[7:0]}};
         SZ_HALF: d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the access engine (master) and memory (slave).
interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   // req/ack: master raises bus_req with stable addr/we/be/wdata and holds it
   // until the cycle bus_ack = 1 (that cycle completes the transfer, rdata is
   // valid with it); ack is ignored whenever bus_req = 0.
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_rdata, bus_ack
   );

endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Selects the addressed byte/half of a read word and sign/zero extends it.
// Purely combinational; also used on the instruction-side path.
module load_formatter
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sext,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: result = {{24{sext & byte_sel[7]}}, byte_sel};
         SZ_HALF: result = {{16{sext & half_sel[15]}}, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store engine: issues one word-aligned bus request per access,
// stalls the pipeline until ack or timeout, and registers formatted load data.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF     // 2**CNT_W must exceed TIMEOUT
) (
   input  logic                  CLK,
   input  logic                  Resetn,
   input  logic                  MemRd_M,
   input  logic                  MemWr_M,
   input  logic [1:0]            MemSize_M,
   input  logic                  MemSext_M,
   input  logic [31:0]           ALUout_M,
   input  logic [31:0]           Wdata_M,
   output logic [31:0]           Do_M,
   output logic                  Stall_M,
   output logic                  AddrErr_M,
   output logic                  BusErr_M,
   mem_access_unit_if.master     bus,
   output state_t                dbg_state
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [1:0]        alo_q, alo_d;
   logic [31:0]       do_q, do_d;
   logic              buserr_q, buserr_d;

   logic              access;
   logic              misaligned;
   logic              issue;
   logic [31:0]       fmt_data;

   assign access     = MemRd_M | MemWr_M;
   assign misaligned = is_misaligned(MemSize_M, ALUout_M[1:0]);
   assign issue      = access & ~misaligned;

   load_formatter u_fmt (
      .rdata   (bus.bus_rdata),
      .addr_lo (alo_q),
      .size    (size_q),
      .sext    (sext_q),
      .result  (fmt_data)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      sext_d   = sext_q;
      alo_d    = alo_q;
      do_d     = do_q;
      buserr_d = buserr_q;

      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d  = BUSY;
               req_d    = 1'b1;
               we_d     = MemWr_M;
               addr_d   = {ALUout_M[31:2], 2'b00};
               be_d     = lane_enables(MemSize_M, ALUout_M[1:0]);
               wdata_d  = lane_data(MemSize_M, Wdata_M);
               size_d   = MemSize_M;
               sext_d   = MemSext_M;
               alo_d    = ALUout_M[1:0];
               cnt_d    = '0;
               buserr_d = 1'b0;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CNT_ONE;
            if (bus.bus_ack) begin
               req_d   = 1'b0;
               state_d = DONE;
               // A write (including rd+wr together) never captures load data.
               if (!we_q) begin
                  do_d = fmt_data;
               end
            end else if (cnt_q == CNT_LAST) begin
               req_d    = 1'b0;
               buserr_d = 1'b1;
               do_d     = '0;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!Resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         size_q   <= SZ_BYTE;
         sext_q   <= 1'b0;
         alo_q    <= '0;
         do_q     <= '0;
         buserr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         sext_q   <= sext_d;
         alo_q    <= alo_d;
         do_q     <= do_d;
         buserr_q <= buserr_d;
      end
   end

   assign Stall_M       = ((state_q == IDLE) & issue) | (state_q == BUSY);
   assign AddrErr_M     = access & misaligned;
   assign Do_M          = do_q;
   assign BusErr_M      = buserr_q;
   assign dbg_state     = state_q;

   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of accesses, a few random
// loads, and a reset-during-BUSY sequence.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        CLK = 1'b0;
   logic        Resetn;
   logic        MemRd_M, MemWr_M, MemSext_M;
   logic [1:0]  MemSize_M;
   logic [31:0] ALUout_M, Wdata_M;
   logic [31:0] Do_M;
   logic        Stall_M, AddrErr_M, BusErr_M;
   state_t      dbg_state;

   mem_access_unit_if bus();

   mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .CLK       (CLK),
      .Resetn    (Resetn),
      .MemRd_M   (MemRd_M),
      .MemWr_M   (MemWr_M),
      .MemSize_M (MemSize_M),
      .MemSext_M (MemSext_M),
      .ALUout_M  (ALUout_M),
      .Wdata_M   (Wdata_M),
      .Do_M      (Do_M),
      .Stall_M   (Stall_M),
      .AddrErr_M (AddrErr_M),
      .BusErr_M  (BusErr_M),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_at;     // BUSY cycle (1-based) carrying ack; 0 = never
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        exp_aerr;
      int          exp_stall;
      logic        exp_berr;
      logic [31:0] exp_do;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic sx, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rdat, input int ack, input logic [3:0] be,
                               input logic [31:0] ewd, input logic aerr, input int stall,
                               input logic berr, input logic [31:0] edo);
      vec_t v;
      v.rd = rd; v.wr = wr; v.size = sz; v.sext = sx; v.addr = addr; v.wdata = wd;
      v.rdata = rdat; v.ack_at = ack; v.exp_be = be; v.exp_wdata = ewd;
      v.exp_aerr = aerr; v.exp_stall = stall; v.exp_berr = berr; v.exp_do = edo;
      return v;
   endfunction

   // Independent reference: shift the addressed lane down, then mask or fill.
   function automatic logic [31:0] ref_fmt(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sx);
      logic [31:0] s;
      s = d >> (int'(a) * 8);
      if (sz == 2'b00) return (sx && s[7])  ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
      if (sz == 2'b01) return (sx && s[15]) ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
      return d;
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] a);
      if (sz == 2'b00) return 4'b0001 << a;
      if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   // Drives one access at posedge+1 and returns at posedge+1 back in IDLE.
   task automatic run_vec(input vec_t v);
      int          stalls;
      int          busy;
      int          c;
      logic [31:0] e;
      MemRd_M = v.rd; MemWr_M = v.wr; MemSize_M = v.size; MemSext_M = v.sext;
      ALUout_M = v.addr; Wdata_M = v.wdata;
      bus.bus_ack = 1'b0; bus.bus_rdata = v.rdata;
      exp_q.push_back(v.exp_do);
      #1;
      chk("addr_err", AddrErr_M, v.exp_aerr);
      stalls = 0; busy = 0;
      for (c = 0; c < 64 && Stall_M; c++) begin
         stalls++;
         if (stalls == 1) begin
            chk("req_idle", bus.bus_req, 1'b0);
         end else begin
            busy++;
            chk("bus_req", bus.bus_req, 1'b1);
            chk("bus_addr", bus.bus_addr, {v.addr[31:2], 2'b00});
            chk("bus_be", bus.bus_be, v.exp_be);
            chk("bus_we", bus.bus_we, v.wr);
            if (v.wr) chk("bus_wdata", bus.bus_wdata, v.exp_wdata);
         end
         bus.bus_ack = (busy != 0) && (busy == v.ack_at);
         @(posedge CLK); #1;
         bus.bus_ack = 1'b0;
      end
      chk("stall_cycles", stalls, v.exp_stall);
      chk("req_after", bus.bus_req, 1'b0);
      chk("bus_err", BusErr_M, v.exp_berr);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("do", Do_M, e);
      end
      if (v.exp_aerr) begin
         // Misaligned access held for a while must never reach the bus.
         for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            chk("mis_req", bus.bus_req, 1'b0);
            chk("mis_stall", Stall_M, 1'b0);
         end
      end
      MemRd_M = 1'b0; MemWr_M = 1'b0;
      @(posedge CLK); #1;
      chk("back_idle", dbg_state, IDLE);
      repeat ($urandom_range(0, 2)) begin
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        v;
      logic [1:0]  sz, a;
      int          ack;
      logic [31:0] rd;
      logic        sx;

      //          rd wr size     sx  addr          wdata         rdata         ack be       exp_wdata     aerr st berr exp_do
      vecs.push_back(mk(1, 0, SZ_WORD, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 4'b1111, 32'h0,        0, 2,  0, 32'hDEAD_BEEF));
      vecs.push_back(mk(1, 0, SZ_BYTE, 1, 32'h0000_0103, 32'h0,        32'h8011_2233, 3, 4'b1000, 32'h0,        0, 4,  0, 32'hFFFF_FF80));
      vecs.push_back(mk(1, 0, SZ_BYTE, 0, 32'h0000_0103, 32'h0,        32'h8011_2233, 3, 4'b1000, 32'h0,        0, 4,  0, 32'h0000_0080));
      vecs.push_back(mk(0, 1, SZ_HALF, 0, 32'h0000_0206, 32'h0000_ABCD, 32'h1234_5678, 1, 4'b1100, 32'hABCD_ABCD, 0, 2,  0, 32'h0000_0080));
      vecs.push_back(mk(0, 1, SZ_BYTE, 0, 32'h0000_0101, 32'h0000_00A5, 32'h9999_9999, 2, 4'b0010, 32'hA5A5_A5A5, 0, 3,  0, 32'h0000_0080));
      vecs.push_back(mk(1, 0, SZ_HALF, 1, 32'h0000_0202, 32'h0,        32'h8001_7FFF, 1, 4'b1100, 32'h0,        0, 2,  0, 32'hFFFF_8001));
      vecs.push_back(mk(1, 0, SZ_HALF, 0, 32'h0000_0200, 32'h0,        32'h1234_F00D, 1, 4'b0011, 32'h0,        0, 2,  0, 32'h0000_F00D));
      vecs.push_back(mk(1, 0, SZ_BYTE, 1, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1, 4'b0010, 32'h0,        0, 2,  0, 32'h0000_007F));
      vecs.push_back(mk(1, 0, SZ_WORD, 0, 32'h0000_0102, 32'h0,        32'h1111_1111, 1, 4'b1111, 32'h0,        1, 0,  0, 32'h0000_007F));
      vecs.push_back(mk(1, 0, SZ_HALF, 1, 32'h0000_0203, 32'h0,        32'h2222_2222, 1, 4'b1000, 32'h0,        1, 0,  0, 32'h0000_007F));
      vecs.push_back(mk(1, 1, SZ_WORD, 0, 32'h0000_0300, 32'h1122_3344, 32'hFFFF_FFFF, 1, 4'b1111, 32'h1122_3344, 0, 2,  0, 32'h0000_007F));
      vecs.push_back(mk(1, 0, 2'b11,   0, 32'h0000_0304, 32'h0,        32'hCAFE_F00D, 2, 4'b1111, 32'h0,        0, 3,  0, 32'hCAFE_F00D));
      vecs.push_back(mk(1, 0, SZ_WORD, 0, 32'h0000_0400, 32'h0,        32'h7777_7777, 0, 4'b1111, 32'h0,        0, 17, 1, 32'h0000_0000));
      vecs.push_back(mk(1, 0, SZ_WORD, 0, 32'h0000_0404, 32'h0,        32'h5A5A_5A5A, 2, 4'b1111, 32'h0,        0, 3,  0, 32'h5A5A_5A5A));
      vecs.push_back(mk(0, 1, SZ_HALF, 0, 32'h0000_0002, 32'hFFFF_1234, 32'h0,        1, 4'b1100, 32'h1234_1234, 0, 2,  0, 32'h5A5A_5A5A));

      // Clock/reset
      Resetn = 1'b0;
      MemRd_M = 1'b0; MemWr_M = 1'b0; MemSize_M = SZ_BYTE; MemSext_M = 1'b0;
      ALUout_M = '0; Wdata_M = '0;
      bus.bus_ack = 1'b0; bus.bus_rdata = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_do", Do_M, 32'h0);
      chk("rst_buserr", BusErr_M, 1'b0);
      chk("rst_req", bus.bus_req, 1'b0);
      chk("rst_stall", Stall_M, 1'b0);
      chk("rst_state", dbg_state, IDLE);
      Resetn = 1'b1;
      @(posedge CLK); #1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Random aligned loads with random ack latency
      for (int i = 0; i < 8; i++) begin
         sz  = 2'($urandom_range(0, 2));
         a   = (sz == SZ_BYTE) ? 2'($urandom_range(0, 3)) :
               (sz == SZ_HALF) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
         ack = $urandom_range(1, 4);
         rd  = $urandom;
         sx  = 1'($urandom_range(0, 1));
         v = mk(1, 0, sz, sx, 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4 + {30'd0, a},
                32'h0, rd, ack, ref_be(sz, a), 32'h0, 0, 1 + ack, 0, ref_fmt(rd, a, sz, sx));
         run_vec(v);
      end

      // Reset during the second BUSY cycle, then a stray ack
      run_vec(mk(1, 0, SZ_WORD, 0, 32'h0000_0504, 32'h0, 32'h1357_9BDF, 1, 4'b1111, 32'h0, 0, 2, 0, 32'h1357_9BDF));
      MemRd_M = 1'b1; MemSize_M = SZ_WORD; ALUout_M = 32'h0000_0500; bus.bus_ack = 1'b0;
      @(posedge CLK); #1;
      chk("rb_busy1_req", bus.bus_req, 1'b1);
      @(posedge CLK); #1;
      chk("rb_busy2_req", bus.bus_req, 1'b1);
      Resetn = 1'b0; MemRd_M = 1'b0;
      @(posedge CLK); #1;
      chk("rb_req", bus.bus_req, 1'b0);
      chk("rb_stall", Stall_M, 1'b0);
      chk("rb_do", Do_M, 32'h0);
      chk("rb_state", dbg_state, IDLE);
      Resetn = 1'b1; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hBADC_0DE5;
      repeat (2) begin
         @(posedge CLK); #1;
      end
      bus.bus_ack = 1'b0;
      chk("late_ack_do", Do_M, 32'h0);
      chk("late_ack_req", bus.bus_req, 1'b0);
      chk("late_ack_stall", Stall_M, 1'b0);
      chk("late_ack_state", dbg_state, IDLE);
      chk("late_ack_buserr", BusErr_M, 1'b0);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
